// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared FSM states, command layout and helpers for the I2C transaction sequencer.
package i2c_seq_pkg;

    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, ACCEPT, DONE, RESP} state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int SEQ_DATA_W = 8;
    localparam int SEQ_REG_W  = 8;
    localparam int SEQ_ADDR_W = 7;

    // Command layout at the default widths; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic                  rw;
        logic [SEQ_ADDR_W-1:0] dev;
        logic [SEQ_REG_W-1:0]  reg_addr;
        logic [SEQ_DATA_W-1:0] data;
    } cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: command/response port and i2c_master link of the sequencer.
interface i2c_txn_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int DIV_WIDTH  = 16
);
    logic [DIV_WIDTH-1:0]  i_divider;
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic                  i_cmd_rw;
    logic [ADDR_WIDTH-1:0] i_cmd_dev;
    logic [REG_WIDTH-1:0]  i_cmd_reg;
    logic [DATA_WIDTH-1:0] i_cmd_data;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic                  o_rsp_rw;
    logic [DATA_WIDTH-1:0] o_rsp_data;
    logic                  o_rsp_timeout;
    logic                  o_rsp_mismatch;
    logic [15:0]           o_mismatch_cnt;
    logic                  o_idle;
    logic                  o_m_enable;
    logic                  o_m_rw;
    logic [DATA_WIDTH-1:0] o_m_mosi;
    logic [REG_WIDTH-1:0]  o_m_reg_addr;
    logic [ADDR_WIDTH-1:0] o_m_device_addr;
    logic [DIV_WIDTH-1:0]  o_m_divider;
    logic [DATA_WIDTH-1:0] i_m_miso;
    logic                  i_m_busy;

    modport slave (
        input  i_divider, i_cmd_valid, i_cmd_rw, i_cmd_dev, i_cmd_reg, i_cmd_data,
               i_rsp_ready, i_m_miso, i_m_busy,
        output o_cmd_ready, o_rsp_valid, o_rsp_rw, o_rsp_data, o_rsp_timeout,
               o_rsp_mismatch, o_mismatch_cnt, o_idle, o_m_enable, o_m_rw, o_m_mosi,
               o_m_reg_addr, o_m_device_addr, o_m_divider
    );

    modport master (
        output i_divider, i_cmd_valid, i_cmd_rw, i_cmd_dev, i_cmd_reg, i_cmd_data,
               i_rsp_ready, i_m_miso, i_m_busy,
        input  o_cmd_ready, o_rsp_valid, o_rsp_rw, o_rsp_data, o_rsp_timeout,
               o_rsp_mismatch, o_mismatch_cnt, o_idle, o_m_enable, o_m_rw, o_m_mosi,
               o_m_reg_addr, o_m_device_addr, o_m_divider
    );
endinterface

// File: rtl/i2c_seq_fifo.sv
// i2c_seq_fifo: synchronous command FIFO, power-of-two DEPTH, async active-high reset.
module i2c_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign o_full  = cnt_q == (AW+1)'(DEPTH);
    assign o_empty = cnt_q == '0;
    assign do_push = i_push && (!o_full || i_pop);
    assign do_pop  = i_pop && (!o_empty || i_push);
    // Empty push+pop passes the incoming word straight through.
    assign o_data  = o_empty ? i_data : mem_q[rd_q];
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: queues single-register I2C commands and runs them one at a time on i2c_master.
// Optional I2C_SEQ_VERIFY_EN: compares read data against the command's expected byte.
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int TIMEOUT    = 1024
) (
    input logic            i_clk,
    input logic            i_rst,
    i2c_txn_sequencer_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] dev;
        logic [REG_WIDTH-1:0]  reg_addr;
        logic [DATA_WIDTH-1:0] data;
    } seq_cmd_t;

    seq_cmd_t              push_cmd, head, cmd_q;
    state_e                state_q;
    logic                  full, empty, pop;
    logic [WD_W-1:0]       wd_q;
    logic                  m_enable_q, m_rw_q;
    logic [DATA_WIDTH-1:0] m_mosi_q;
    logic [REG_WIDTH-1:0]  m_reg_q;
    logic [ADDR_WIDTH-1:0] m_dev_q;
    logic [DIV_WIDTH-1:0]  m_div_q;
    logic                  rsp_valid_q, rsp_rw_q, rsp_timeout_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
`ifdef I2C_SEQ_VERIFY_EN
    logic                  rsp_mismatch_q;
    logic [15:0]           mis_cnt_q;
`endif

    assign push_cmd = '{rw: bus.i_cmd_rw, dev: bus.i_cmd_dev, reg_addr: bus.i_cmd_reg, data: bus.i_cmd_data};
    // A pending response blocks the next pop so responses never overtake each other.
    assign pop = state_q == IDLE && !empty && !rsp_valid_q;

    i2c_seq_fifo #(.WIDTH($bits(seq_cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (bus.i_cmd_valid && !full),
        .i_pop   (pop),
        .i_data  (push_cmd),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            wd_q          <= '0;
            m_enable_q    <= 1'b0;
            m_rw_q        <= 1'b0;
            m_mosi_q      <= '0;
            m_reg_q       <= '0;
            m_dev_q       <= '0;
            m_div_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rw_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
`ifdef I2C_SEQ_VERIFY_EN
            rsp_mismatch_q <= 1'b0;
            mis_cnt_q      <= '0;
`endif
        end else begin
            if (rsp_valid_q && bus.i_rsp_ready) rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (pop) begin
                    cmd_q   <= head;
                    state_q <= LAUNCH;
                end
                LAUNCH: begin
                    m_rw_q        <= cmd_q.rw;
                    m_dev_q       <= cmd_q.dev;
                    m_reg_q       <= cmd_q.reg_addr;
                    m_mosi_q      <= cmd_q.data;
                    m_div_q       <= bus.i_divider;
                    rsp_rw_q      <= cmd_q.rw;
                    rsp_data_q    <= '0;
                    rsp_timeout_q <= 1'b0;
`ifdef I2C_SEQ_VERIFY_EN
                    rsp_mismatch_q <= 1'b0;
`endif
                    state_q       <= ARM;
                end
                ARM: if (!bus.i_m_busy) begin
                    m_enable_q <= 1'b1;
                    wd_q       <= '0;
                    state_q    <= ACCEPT;
                end
                ACCEPT: if (bus.i_m_busy) begin
                    m_enable_q <= 1'b0;
                    state_q    <= DONE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    m_enable_q    <= 1'b0;
                    rsp_timeout_q <= 1'b1;
                    state_q       <= RESP;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
                // No watchdog here: transfer length scales with the SCL divider.
                DONE: if (!bus.i_m_busy) begin
                    rsp_data_q <= (m_rw_q == RW_READ) ? bus.i_m_miso : '0;
`ifdef I2C_SEQ_VERIFY_EN
                    if (m_rw_q == RW_READ && bus.i_m_miso != m_mosi_q) begin
                        rsp_mismatch_q <= 1'b1;
                        mis_cnt_q      <= sat_inc16(mis_cnt_q);
                    end
`endif
                    state_q <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_cmd_ready     = !full;
    assign bus.o_idle          = empty && state_q == IDLE && !rsp_valid_q;
    assign bus.o_rsp_valid     = rsp_valid_q;
    assign bus.o_rsp_rw        = rsp_rw_q;
    assign bus.o_rsp_data      = rsp_data_q;
    assign bus.o_rsp_timeout   = rsp_timeout_q;
    assign bus.o_m_enable      = m_enable_q;
    assign bus.o_m_rw          = m_rw_q;
    assign bus.o_m_mosi        = m_mosi_q;
    assign bus.o_m_reg_addr    = m_reg_q;
    assign bus.o_m_device_addr = m_dev_q;
    assign bus.o_m_divider     = m_div_q;
`ifdef I2C_SEQ_VERIFY_EN
    assign bus.o_rsp_mismatch  = rsp_mismatch_q;
    assign bus.o_mismatch_cnt  = mis_cnt_q;
`else
    assign bus.o_rsp_mismatch  = 1'b0;
    assign bus.o_mismatch_cnt  = '0;
`endif
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed bench with a behavioural i2c_master/slave register model.
module tb_i2c_txn_sequencer;
`ifdef I2C_SEQ_VERIFY_EN
    localparam logic [31:0] VER = 1;
`else
    localparam logic [31:0] VER = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_txn_sequencer_if bus ();
    i2c_txn_sequencer dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic       model_en = 1'b0;
    logic       model_busy = 1'b0;
    logic       man_busy = 1'b0;
    int         model_cnt = 0;
    logic [7:0] mem [256] = '{default: 8'h00};

    assign bus.i_m_busy = model_en ? model_busy : man_busy;

    // Master model: busy one cycle after enable, stays busy for a few cycles, then completes.
    always @(negedge clk) begin
        if (rst) begin
            model_busy = 1'b0;
            model_cnt  = 0;
        end else if (model_en) begin
            if (!model_busy && bus.o_m_enable) begin
                model_busy = 1'b1;
                model_cnt  = 4;
            end else if (model_busy) begin
                if (model_cnt == 0) begin
                    model_busy = 1'b0;
                    if (bus.o_m_rw) bus.i_m_miso = mem[bus.o_m_reg_addr];
                    else mem[bus.o_m_reg_addr] = bus.o_m_mosi;
                end else begin
                    model_cnt--;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] d);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_rw    = rw;
        bus.i_cmd_dev   = dev;
        bus.i_cmd_reg   = ra;
        bus.i_cmd_data  = d;
        tick();
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!bus.o_rsp_valid && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.o_rsp_valid), 1);
    endtask

    task automatic consume;
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic rw, input logic [7:0] d, input logic to);
        wait_rsp(tag);
        check({tag, "_rw"}, 32'(bus.o_rsp_rw), 32'(rw));
        check({tag, "_data"}, 32'(bus.o_rsp_data), 32'(d));
        check({tag, "_timeout"}, 32'(bus.o_rsp_timeout), 32'(to));
        consume();
        check({tag, "_released"}, 32'(bus.o_rsp_valid), 0);
    endtask

    initial begin
        int n;
        int bad;
        bus.i_divider   = '0;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_rw    = 1'b0;
        bus.i_cmd_dev   = '0;
        bus.i_cmd_reg   = '0;
        bus.i_cmd_data  = '0;
        bus.i_rsp_ready = 1'b0;
        bus.i_m_miso    = '0;
        tick();
        tick();
        check("rst_ready", 32'(bus.o_cmd_ready), 1);
        check("rst_idle", 32'(bus.o_idle), 1);
        check("rst_enable", 32'(bus.o_m_enable), 0);
        check("rst_rsp_valid", 32'(bus.o_rsp_valid), 0);
        check("rst_divider", 32'(bus.o_m_divider), 0);
        check("rst_miscnt", 32'(bus.o_mismatch_cnt), 0);
        rst = 1'b0;
        tick();

        // Write then read back, with enable latency from the first push.
        model_en = 1'b1;
        bus.i_divider = 16'h0003;
        push(1'b0, 7'h11, 8'h00, 8'hDC);
        tick();
        check("lat_c1", 32'(bus.o_m_enable), 0);
        tick();
        check("lat_c2", 32'(bus.o_m_enable), 0);
        tick();
        check("lat_c3", 32'(bus.o_m_enable), 1);
        check("wr_dev", 32'(bus.o_m_device_addr), 32'h11);
        check("wr_div", 32'(bus.o_m_divider), 32'h3);
        check("wr_mosi", 32'(bus.o_m_mosi), 32'hDC);
        push(1'b1, 7'h11, 8'h00, 8'hDC);
        expect_rsp("wr1", 1'b0, 8'h00, 1'b0);
        wait_rsp("rd1");
        check("rd1_rw", 32'(bus.o_rsp_rw), 1);
        check("rd1_data", 32'(bus.o_rsp_data), 32'hDC);
        check("rd1_timeout", 32'(bus.o_rsp_timeout), 0);

        // FIFO full: the pending read response stalls the sequencer.
        model_en = 1'b0;
        man_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("full_ready_7", 32'(bus.o_cmd_ready), 1);
            if (i % 2 == 0) push(1'b0, 7'h22, 8'(i / 2 + 1), 8'(8'h30 + i));
            else push(1'b1, 7'h22, 8'((i - 1) / 2 + 1), 8'(8'h30 + i - 1));
        end
        check("full_ready_8", 32'(bus.o_cmd_ready), 0);
        check("full_idle", 32'(bus.o_idle), 0);
        push(1'b0, 7'h22, 8'h05, 8'hEE);
        check("full_ready_9", 32'(bus.o_cmd_ready), 0);
        consume();
        model_en = 1'b1;
        for (int i = 0; i < 8; i++)
            expect_rsp($sformatf("full_r%0d", i), 1'(i % 2), (i % 2 == 1) ? 8'(8'h30 + i - 1) : 8'h00, 1'b0);
        repeat (30) tick();
        check("full_extra_idle", 32'(bus.o_idle), 1);
        check("full_extra_rsp", 32'(bus.o_rsp_valid), 0);
        check("full_drop_mem", 32'(mem[5]), 0);

        // Timeout: master never goes busy.
        model_en = 1'b0;
        man_busy = 1'b0;
        push(1'b0, 7'h33, 8'h07, 8'h77);
        push(1'b1, 7'h33, 8'h01, 8'h30);
        n = 0;
        while (!bus.o_m_enable && n < 20) begin
            tick();
            n++;
        end
        check("to_enable", 32'(bus.o_m_enable), 1);
        n = 0;
        while (bus.o_m_enable && n < 3000) begin
            tick();
            n++;
        end
        check("to_len", 32'(n), 1024);
        model_en = 1'b1;
        expect_rsp("to1", 1'b0, 8'h00, 1'b1);
        expect_rsp("to_next", 1'b1, 8'h30, 1'b0);

        // Backpressure: first response must hold and block the second launch.
        push(1'b0, 7'h44, 8'h02, 8'h5A);
        push(1'b1, 7'h44, 8'h02, 8'h5A);
        wait_rsp("bp1");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!bus.o_rsp_valid || bus.o_rsp_rw !== 1'b0 || bus.o_rsp_data !== 8'h00 || bus.o_m_enable) bad++;
        end
        check("bp_hold", 32'(bad), 0);
        check("bp_no_launch", 32'(bus.o_m_rw), 0);
        consume();
        expect_rsp("bp2", 1'b1, 8'h5A, 1'b0);

        // Reset while the master is busy (sequencer in DONE) with another command queued.
        push(1'b1, 7'h55, 8'h02, 8'h5A);
        push(1'b0, 7'h55, 8'h09, 8'h99);
        n = 0;
        while (!(bus.i_m_busy && !bus.o_m_enable) && n < 50) begin
            tick();
            n++;
        end
        check("mid_done_seen", 32'(bus.i_m_busy && !bus.o_m_enable), 1);
        rst = 1'b1;
        #1;
        check("mid_enable", 32'(bus.o_m_enable), 0);
        check("mid_rsp_valid", 32'(bus.o_rsp_valid), 0);
        check("mid_idle", 32'(bus.o_idle), 1);
        check("mid_ready", 32'(bus.o_cmd_ready), 1);
        check("mid_divider", 32'(bus.o_m_divider), 0);
        check("mid_reg", 32'(bus.o_m_reg_addr), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (40) tick();
        check("mid_after_rsp", 32'(bus.o_rsp_valid), 0);
        check("mid_after_idle", 32'(bus.o_idle), 1);
        check("mid_lost_mem", 32'(mem[9]), 0);

        // Verify: expected 8'hAA but slave holds 8'hDC.
        push(1'b1, 7'h11, 8'h00, 8'hAA);
        wait_rsp("vf");
        check("vf_data", 32'(bus.o_rsp_data), 32'hDC);
        check("vf_mismatch", 32'(bus.o_rsp_mismatch), VER);
        check("vf_cnt", 32'(bus.o_mismatch_cnt), VER);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
Synthesizable transaction sequencer in front of i2c_master; replaces hand-written enable/busy handshakes in benches and firmware glue.
Accepts single-register read/write commands into a DEPTH-entry command FIFO and drives the master's enable/rw/address/data/divider inputs one transaction at a time.
Returns one response per command (read data or write-ack) through a valid/ready port, with a busy-accept timeout watchdog.
Sits between the RISC-V Otter MMIO decode and i2c_master.

Parameters:
DATA_WIDTH, 8, data byte width; matches i2c_master DATA_WIDTH
REG_WIDTH, 8, slave register address width
ADDR_WIDTH, 7, slave device address width
DEPTH, 8, command FIFO entries; power of two, >= 2
DIV_WIDTH, 16, SCL divider width
TIMEOUT, 1024, cycles allowed from enable=1 to i_m_busy=1 before abort

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_divider  in  DIV_WIDTH  SCL divider; sampled at each command launch
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  FIFO not full
i_cmd_rw  in  1  0=write, 1=read
i_cmd_dev  in  ADDR_WIDTH  slave address
i_cmd_reg  in  REG_WIDTH  register address
i_cmd_data  in  DATA_WIDTH  write data; expected data for reads under I2C_SEQ_VERIFY_EN
o_rsp_valid  out  1  response held
i_rsp_ready  in  1  response consumed
o_rsp_rw  out  1  rw of completed command
o_rsp_data  out  DATA_WIDTH  read data (0 for writes)
o_rsp_timeout  out  1  command aborted by watchdog
o_rsp_mismatch  out  1  verify failure (0 without macro)
o_mismatch_cnt  out  16  saturating mismatch count (0 without macro)
o_idle  out  1  FIFO empty, FSM in IDLE, no response pending
o_m_enable, o_m_rw  out  1 each  to i2c_master
o_m_mosi  out  DATA_WIDTH  to i2c_master
o_m_reg_addr  out  REG_WIDTH  to i2c_master
o_m_device_addr  out  ADDR_WIDTH  to i2c_master
o_m_divider  out  DIV_WIDTH  to i2c_master
i_m_miso  in  DATA_WIDTH  from i2c_master
i_m_busy  in  1  from i2c_master

Behaviour:
- Reset (async): all outputs 0, except o_cmd_ready=1 and o_idle=1; FIFO empty; FSM=IDLE; watchdog and mismatch counter cleared.
- FIFO push on i_cmd_valid&&o_cmd_ready; o_cmd_ready=0 when DEPTH entries held; push while full is ignored. Pointers wrap modulo DEPTH; simultaneous push and pop when full or empty is legal, count unchanged.
- FSM states: IDLE -> LAUNCH -> ARM -> ACCEPT -> DONE -> RESP -> IDLE.
- IDLE: FIFO non-empty and !o_rsp_valid -> pop, go LAUNCH.
- LAUNCH: register rw/dev/reg/data and i_divider onto o_m_*; these hold stable until the next LAUNCH. -> ARM.
- ARM: wait i_m_busy==0, then o_m_enable<=1, clear watchdog -> ACCEPT.
- ACCEPT: i_m_busy==1 -> o_m_enable<=0 -> DONE. Watchdog reaching TIMEOUT-1 -> o_m_enable<=0, timeout flag set -> RESP.
- DONE: i_m_busy==0 -> capture i_m_miso if read (o_rsp_data=0 for writes) -> RESP. No timeout in DONE, since the master's SCL length is divider-dependent.
- RESP: o_rsp_valid<=1 -> IDLE. o_rsp_valid stays high and the payload is stable until i_rsp_ready. Response handshake completes in the cycle valid&&ready.
- Minimum command-to-enable latency from FIFO non-empty: 3 cycles (IDLE, LAUNCH, ARM).
- One command in flight; FIFO accepts pushes during execution.
- Reset mid-transaction: o_m_enable drops immediately and all queued commands are lost. The master receives the same i_rst and is reset alongside.

Optional Feature:
I2C_SEQ_VERIFY_EN:
- Defined: for reads, i_cmd_data is the expected value.
- Defined: in DONE, miso!=expected sets o_rsp_mismatch and increments o_mismatch_cnt, saturating at 16'hFFFF.
- Undefined: the compare logic and counter are not built; o_rsp_mismatch and o_mismatch_cnt are tied to 0.

Decomposition:
- Package i2c_seq_pkg holds:
  - state enum (IDLE, LAUNCH, ARM, ACCEPT, DONE, RESP)
  - packed command struct {rw, dev, reg, data}
  - RW_WRITE/RW_READ constants
- One sub-module, i2c_seq_fifo: synchronous FIFO parametrised by width and DEPTH, async active-high reset, with full/empty outputs.

Test Plan:
- Write then read-back: push write (dev 7'h11, reg 0, data 8'hDC), then read (dev 7'h11, reg 0) against the slave model, divider 16'h0003. Expect 2 responses in order; read response o_rsp_data=8'hDC, o_rsp_timeout=0.
- FIFO full: i_m_busy held high and stalled, push DEPTH+1 commands. Expect o_cmd_ready=0 after entry DEPTH, extra push dropped, and exactly DEPTH responses after release.
- Timeout: i_m_busy tied 0, push a write. Expect o_m_enable high for exactly TIMEOUT cycles, then a response with o_rsp_timeout=1, then the next command proceeds.
- Backpressure: i_rsp_ready=0 for 50 cycles with 2 commands queued. Expect the first response held stable and no second launch until ready.
- Reset mid-op: assert i_rst during DONE. Expect all outputs at reset values immediately, o_idle=1, and no response emitted.
- Verify (macro defined): read reg 0 expecting 8'hAA while the slave returns 8'hDC. Expect o_rsp_mismatch=1 and o_mismatch_cnt=1.
